// File: rtl/fir_pkg.sv
// Shared types and index helpers for the 11-tap FIR sequencer.
package fir_pkg;

    localparam int NTAP       = 11;
    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 12;
    localparam int IDX_W      = 4;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_IN,
        ST_MAC,
        ST_DRAIN,
        ST_OUT,
        ST_DONE
    } state_t;

    function automatic logic [ADDR_W-1:0] byte_addr(input idx_t idx);
        return ADDR_W'(idx) * ADDR_W'(WORD_BYTES);
    endfunction

    // (ptr - k) mod NTAP without a divider; ptr and k are both below NTAP.
    function automatic idx_t circ_idx(input idx_t ptr, input idx_t k);
        return (ptr >= k) ? ptr - k : ptr + idx_t'(NTAP) - k;
    endfunction

    function automatic idx_t wrap_inc(input idx_t i);
        return (i == idx_t'(NTAP - 1)) ? '0 : i + idx_t'(1);
    endfunction

endpackage

// File: rtl/fir_sched_if.sv
// AXI-Stream channel used for both the sample input and the result output.
interface fir_sched_if #(
    parameter int DW = 32
);
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [DW-1:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/fir_mac.sv
// Registered multiply-accumulate: acc <= clr ? 0 : acc + a*b (wrapping, low word).
module fir_mac #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] acc
);

    // The low W bits of a two's-complement product equal those of the
    // unsigned product, so a W-bit multiply gives the signed result directly.
    logic [W-1:0] prod_lo;
    assign prod_lo = a * b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_lo;
        end
    end

endmodule

// File: rtl/fir_sched.sv
// FIR sequencer: run control, data-RAM clear/fill, 11-tap MAC loop, stream
// handshakes and tap-RAM arbitration between configuration and compute.
module fir_sched
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,

    input  logic                   cfg_start,
    input  logic [31:0]            cfg_len,
    input  logic                   cfg_stat_rd,
    output logic                   ap_idle,
    output logic                   ap_done,
    output logic                   err_tlast,

    input  logic                   cfg_tap_req,
    input  logic                   cfg_tap_we,
    input  logic [3:0]             cfg_tap_idx,
    input  logic [pDATA_WIDTH-1:0] cfg_tap_wdata,
    output logic                   cfg_tap_gnt,
    output logic                   cfg_tap_rvalid,
    output logic [pDATA_WIDTH-1:0] cfg_tap_rdata,

    fir_sched_if.slave             ss,
    fir_sched_if.master            sm,

    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    input  logic [pDATA_WIDTH-1:0] tap_Do,

    output logic [3:0]             data_WE,
    output logic                   data_EN,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic [pDATA_WIDTH-1:0] data_Di,
    input  logic [pDATA_WIDTH-1:0] data_Do
);

    localparam idx_t LAST_K = idx_t'(Tape_Num - 1);

    state_t state, next_state;

    idx_t        k;
    idx_t        ptr;
    logic [31:0] count;
    logic [31:0] len_q;
    logic        done_q;
    logic        err_q;
    logic        rvalid_q;
    logic        rd_pend;

    logic        start_acc;
    logic        accept;
    logic        last_sample;
    logic [pDATA_WIDTH-1:0] acc;

    assign start_acc   = (state == ST_IDLE) && cfg_start;
    assign accept      = (state == ST_WAIT_IN) && ss.tvalid;
    assign last_sample = (count + 32'd1) == len_q;

    assign ap_idle     = (state == ST_IDLE) || (state == ST_DONE);
    assign ap_done     = done_q;
    assign err_tlast   = err_q;

    assign cfg_tap_gnt    = cfg_tap_req && ap_idle;
    assign cfg_tap_rvalid = rvalid_q;
    assign cfg_tap_rdata  = rvalid_q ? tap_Do : '0;

    assign sm.tvalid = (state == ST_OUT);
    assign sm.tlast  = (state == ST_OUT) && (count == len_q);
    assign sm.tdata  = acc;

    // NOTE: state and counters use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no branch
    // can leave a signal unassigned and infer a latch.
    always_comb begin
        next_state = state;
        ss.tready  = 1'b0;
        data_EN    = 1'b0;
        data_WE    = 4'h0;
        data_A     = '0;
        data_Di    = '0;
        tap_EN     = 1'b0;
        tap_WE     = 4'h0;
        tap_A      = '0;
        tap_Di     = '0;

        unique case (state)
            ST_IDLE: begin
                if (cfg_start) next_state = ST_CLEAR;
            end
            ST_CLEAR: begin
                // A zero-length run has nothing to filter; finish at once.
                if (len_q == 32'd0) begin
                    next_state = ST_DONE;
                end else begin
                    data_EN = 1'b1;
                    data_WE = 4'hF;
                    data_A  = pADDR_WIDTH'(byte_addr(k));
                    if (k == LAST_K) next_state = ST_WAIT_IN;
                end
            end
            ST_WAIT_IN: begin
                ss.tready = 1'b1;
                if (ss.tvalid) begin
                    data_EN    = 1'b1;
                    data_WE    = 4'hF;
                    data_A     = pADDR_WIDTH'(byte_addr(ptr));
                    data_Di    = ss.tdata;
                    next_state = ST_MAC;
                end
            end
            ST_MAC: begin
                tap_EN  = 1'b1;
                tap_A   = pADDR_WIDTH'(byte_addr(k));
                data_EN = 1'b1;
                data_A  = pADDR_WIDTH'(byte_addr(circ_idx(ptr, k)));
                if (k == LAST_K) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                next_state = ST_OUT;
            end
            ST_OUT: begin
                if (sm.tready) next_state = (count == len_q) ? ST_DONE : ST_WAIT_IN;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        // The engine only touches the tap RAM while busy, so an idle-time
        // configuration access never collides with it.
        if (cfg_tap_gnt) begin
            tap_EN = 1'b1;
            tap_WE = cfg_tap_we ? 4'hF : 4'h0;
            tap_A  = pADDR_WIDTH'(byte_addr(cfg_tap_idx));
            tap_Di = cfg_tap_wdata;
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            k        <= '0;
            ptr      <= '0;
            count    <= '0;
            len_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rd_pend  <= 1'b0;
        end else begin
            rvalid_q <= cfg_tap_gnt && !cfg_tap_we;
            rd_pend  <= (state == ST_MAC);

            // Entering DONE outranks a coincident status read.
            if (next_state == ST_DONE) begin
                done_q <= 1'b1;
            end else if (cfg_stat_rd || start_acc) begin
                done_q <= 1'b0;
            end

            if (start_acc) begin
                err_q <= 1'b0;
            end else if (accept && (ss.tlast != last_sample)) begin
                err_q <= 1'b1;
            end

            if (start_acc) begin
                len_q <= cfg_len;
                count <= '0;
                k     <= '0;
                ptr   <= '0;
            end

            case (state)
                ST_CLEAR, ST_MAC: begin
                    k <= (k == LAST_K) ? '0 : k + idx_t'(1);
                end
                ST_WAIT_IN: begin
                    if (accept) begin
                        count <= count + 32'd1;
                        k     <= '0;
                    end
                end
                ST_DRAIN: begin
                    ptr <= wrap_inc(ptr);
                end
                default: begin
                end
            endcase
        end
    end

    // RAM data returns one cycle after each MAC read, so accumulation is
    // enabled by the registered "read issued" flag, which also covers DRAIN.
    fir_mac #(
        .W (pDATA_WIDTH)
    ) u_mac (
        .clk (axis_clk),
        .rst (axis_rst),
        .clr (accept),
        .en  (rd_pend),
        .a   (tap_Do),
        .b   (data_Do),
        .acc (acc)
    );

endmodule

// File: tb/tb_fir_sched.sv
// Scoreboard bench for fir_sched with behavioural single-port BRAMs.
module tb_fir_sched;

    logic        axis_clk = 1'b0;
    logic        axis_rst;
    logic        cfg_start, cfg_stat_rd;
    logic [31:0] cfg_len;
    logic        ap_idle, ap_done, err_tlast;
    logic        cfg_tap_req, cfg_tap_we;
    logic [3:0]  cfg_tap_idx;
    logic [31:0] cfg_tap_wdata;
    logic        cfg_tap_gnt, cfg_tap_rvalid;
    logic [31:0] cfg_tap_rdata;
    logic [3:0]  tap_WE, data_WE;
    logic        tap_EN, data_EN;
    logic [11:0] tap_A, data_A;
    logic [31:0] tap_Di, tap_Do, data_Di, data_Do;

    fir_sched_if #(.DW(32)) ss_if ();
    fir_sched_if #(.DW(32)) sm_if ();

    fir_sched dut (
        .axis_clk       (axis_clk),
        .axis_rst       (axis_rst),
        .cfg_start      (cfg_start),
        .cfg_len        (cfg_len),
        .cfg_stat_rd    (cfg_stat_rd),
        .ap_idle        (ap_idle),
        .ap_done        (ap_done),
        .err_tlast      (err_tlast),
        .cfg_tap_req    (cfg_tap_req),
        .cfg_tap_we     (cfg_tap_we),
        .cfg_tap_idx    (cfg_tap_idx),
        .cfg_tap_wdata  (cfg_tap_wdata),
        .cfg_tap_gnt    (cfg_tap_gnt),
        .cfg_tap_rvalid (cfg_tap_rvalid),
        .cfg_tap_rdata  (cfg_tap_rdata),
        .ss             (ss_if),
        .sm             (sm_if),
        .tap_WE         (tap_WE),
        .tap_EN         (tap_EN),
        .tap_A          (tap_A),
        .tap_Di         (tap_Di),
        .tap_Do         (tap_Do),
        .data_WE        (data_WE),
        .data_EN        (data_EN),
        .data_A         (data_A),
        .data_Di        (data_Di),
        .data_Do        (data_Do)
    );

    always #5 axis_clk = ~axis_clk;

    logic [31:0] tap_mem  [16];
    logic [31:0] data_mem [16];

    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) tap_mem[tap_A[5:2]] <= tap_Di;
            tap_Do <= tap_mem[tap_A[5:2]];
        end
        if (data_EN) begin
            if (data_WE == 4'hF) data_mem[data_A[5:2]] <= data_Di;
            data_Do <= data_mem[data_A[5:2]];
        end
    end

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   out_cnt  = 0;
    int   stall_at = -1;
    int   stall_left = 0;
    logic [31:0] stall_val = '0;

    int taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    int exp2 [12] = '{0, -10, -19, 4, 60, 123, 179, 202, 193, 183, 183, 183};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name,
                     $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge axis_clk);
            if (axis_rst === 1'b0 && sm_if.tvalid && sm_if.tready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got %0d, expected no output", $signed(sm_if.tdata));
                end else begin
                    e = sb.pop_front();
                    check($sformatf("out%0d_data", out_cnt), sm_if.tdata, e.data);
                    check_bit($sformatf("out%0d_last", out_cnt), sm_if.tlast, e.last);
                end
                out_cnt++;
            end
        end
    end

    // Output back-pressure: holds tready low for stall_left cycles at output stall_at.
    initial begin
        sm_if.tready = 1'b1;
        forever begin
            @(posedge axis_clk);
            #1;
            if (stall_left > 0 && sm_if.tvalid && out_cnt == stall_at) begin
                sm_if.tready = 1'b0;
                stall_left--;
                check_bit("stall_valid", sm_if.tvalid, 1'b1);
                check("stall_data", sm_if.tdata, stall_val);
                check_bit("stall_ss_ready", ss_if.tready, 1'b0);
            end else begin
                sm_if.tready = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic start_run(input logic [31:0] len);
        @(posedge axis_clk); #1;
        cfg_len   = len;
        cfg_start = 1'b1;
        @(posedge axis_clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        bit got = 1'b0;
        ss_if.tvalid = 1'b1;
        ss_if.tdata  = d;
        ss_if.tlast  = last;
        for (int i = 0; i < 100; i++) begin
            @(negedge axis_clk);
            if (ss_if.tready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_bit("ss_tready_timeout", ss_if.tready, 1'b1);
        @(posedge axis_clk); #1;
        ss_if.tvalid = 1'b0;
        ss_if.tlast  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge axis_clk);
            if (ap_done) break;
        end
        check_bit({name, "_ap_done"}, ap_done, 1'b1);
        check_bit({name, "_ap_idle"}, ap_idle, 1'b1);
    endtask

    task automatic tap_write(input logic [3:0] idx, input logic [31:0] val);
        cfg_tap_req   = 1'b1;
        cfg_tap_we    = 1'b1;
        cfg_tap_idx   = idx;
        cfg_tap_wdata = val;
        @(negedge axis_clk);
        check_bit($sformatf("tap_wr%0d_gnt", idx), cfg_tap_gnt, 1'b1);
        @(posedge axis_clk); #1;
        cfg_tap_req = 1'b0;
        cfg_tap_we  = 1'b0;
    endtask

    // Tap read issued while a run is busy; it must stall until ap_idle.
    task automatic tap_read_busy();
        bit got = 1'b0;
        repeat (20) @(posedge axis_clk);
        #1;
        cfg_tap_req = 1'b1;
        cfg_tap_we  = 1'b0;
        cfg_tap_idx = 4'd5;
        for (int i = 0; i < 600; i++) begin
            @(negedge axis_clk);
            if (!ap_idle) begin
                check_bit("tap_gnt_busy", cfg_tap_gnt, 1'b0);
            end else begin
                check_bit("tap_gnt_idle", cfg_tap_gnt, 1'b1);
                got = 1'b1;
                break;
            end
        end
        if (!got) check_bit("tap_gnt_timeout", ap_idle, 1'b1);
        @(posedge axis_clk); #1;
        cfg_tap_req = 1'b0;
        @(negedge axis_clk);
        check_bit("tap_rvalid", cfg_tap_rvalid, 1'b1);
        check("tap_rdata", cfg_tap_rdata, 32'd63);
    endtask

    initial begin
        axis_rst      = 1'b1;
        cfg_start     = 1'b0;
        cfg_stat_rd   = 1'b0;
        cfg_len       = '0;
        cfg_tap_req   = 1'b0;
        cfg_tap_we    = 1'b0;
        cfg_tap_idx   = '0;
        cfg_tap_wdata = '0;
        ss_if.tvalid  = 1'b0;
        ss_if.tlast   = 1'b0;
        ss_if.tdata   = '0;
        repeat (3) @(posedge axis_clk);
        #1 axis_rst = 1'b0;

        @(negedge axis_clk);
        check_bit("rst_ap_idle", ap_idle, 1'b1);
        check_bit("rst_ap_done", ap_done, 1'b0);
        check_bit("rst_err_tlast", err_tlast, 1'b0);
        check_bit("rst_ss_tready", ss_if.tready, 1'b0);
        check_bit("rst_sm_tvalid", sm_if.tvalid, 1'b0);
        check_bit("rst_tap_en", tap_EN, 1'b0);
        check_bit("rst_data_en", data_EN, 1'b0);
        check("rst_sm_tdata", sm_if.tdata, 32'd0);

        @(posedge axis_clk); #1;
        for (int i = 0; i < 11; i++) tap_write(4'(i), 32'(taps[i]));

        // Run 1: impulse response reproduces the taps.
        for (int i = 0; i < 11; i++) sb.push_back('{data: 32'(taps[i]), last: (i == 10)});
        start_run(32'd11);
        for (int i = 0; i < 11; i++) send((i == 0) ? 32'd1 : 32'd0, (i == 10));
        wait_done("run1");
        check_bit("run1_err_tlast", err_tlast, 1'b0);
        @(posedge axis_clk); #1 cfg_stat_rd = 1'b1;
        @(posedge axis_clk); #1 cfg_stat_rd = 1'b0;
        @(negedge axis_clk);
        check_bit("stat_rd_clears_done", ap_done, 1'b0);

        // Run 2: step response with a 5-cycle output stall and a busy tap read.
        for (int i = 0; i < 12; i++) sb.push_back('{data: 32'(exp2[i]), last: (i == 11)});
        stall_at   = out_cnt + 3;
        stall_val  = 32'(exp2[3]);
        stall_left = 5;
        start_run(32'd12);
        fork
            begin
                for (int i = 0; i < 12; i++) send(32'd1, (i == 11));
                wait_done("run2");
            end
            tap_read_busy();
        join
        check_bit("run2_err_tlast", err_tlast, 1'b0);
        check("stall_cycles_used", 32'(stall_left), 32'd0);

        // Run 3: tlast on sample 2 of 3; the run still completes.
        sb.push_back('{data: 32'd0, last: 1'b0});
        sb.push_back('{data: 32'(-50), last: 1'b0});
        sb.push_back('{data: 32'(-25), last: 1'b1});
        start_run(32'd3);
        @(negedge axis_clk);
        check_bit("start_clears_done", ap_done, 1'b0);
        send(32'd5, 1'b0);
        send(32'(-2), 1'b1);
        @(negedge axis_clk);
        check_bit("run3_err_set", err_tlast, 1'b1);
        send(32'd7, 1'b0);
        wait_done("run3");
        check_bit("run3_err_sticky", err_tlast, 1'b1);

        // Run 4: zero length finishes within two cycles with no stream traffic.
        start_run(32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge axis_clk);
            check_bit("len0_ss_tready", ss_if.tready, 1'b0);
            check_bit("len0_sm_tvalid", sm_if.tvalid, 1'b0);
            if (ap_done) break;
        end
        check_bit("len0_ap_done", ap_done, 1'b1);
        check_bit("len0_err_cleared", err_tlast, 1'b0);

        repeat (5) @(posedge axis_clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fir_sched.md
# fir_sched

Sequencer and MAC engine for the 11-tap FIR. It sits between the AXI-lite register front end and the two single-port BRAMs (tap RAM, data RAM). It owns the ap_start/ap_done/ap_idle state machine and the AXI-Stream input/output handshakes. It also arbitrates the tap RAM between configuration accesses and the compute loop.

## Interface
- pADDR_WIDTH, 12, BRAM byte-address width
- pDATA_WIDTH, 32, data/tap/accumulator width
- Tape_Num, 11, number of taps and data-RAM depth in words

- axis_clk  in  1  sole clock, rising edge
- axis_rst  in  1  asynchronous, active-high reset
- cfg_start  in  1  one-cycle pulse: ap_start written 1
- cfg_len  in  32  data_length register (samples per run)
- cfg_stat_rd  in  1  one-cycle pulse: status register (0x00) read
- ap_idle, ap_done  out  1  status bits 2 and 1
- err_tlast  out  1  sticky: ss_tlast disagreed with sample count
- cfg_tap_req, cfg_tap_we  in  1  config tap access request, write enable
- cfg_tap_idx  in  4  tap index 0..10
- cfg_tap_wdata  in  32  tap write data
- cfg_tap_gnt  out  1  access performed this cycle
- cfg_tap_rvalid  out  1  cfg_tap_rdata valid (cycle after read grant)
- cfg_tap_rdata  out  32  tap read data
- ss_tvalid, ss_tlast  in  1 ; ss_tdata  in  32 ; ss_tready  out  1
- sm_tready  in  1 ; sm_tvalid, sm_tlast  out  1 ; sm_tdata  out  32
- tap_WE  out  4 ; tap_EN  out  1 ; tap_A  out  12 ; tap_Di  out  32 ; tap_Do  in  32
- data_WE  out  4 ; data_EN  out  1 ; data_A  out  12 ; data_Di  out  32 ; data_Do  in  32

## Operation
- States: IDLE, CLEAR, WAIT_IN, MAC, DRAIN, OUT, DONE.
- IDLE: ap_idle=1. cfg_start moves to CLEAR and clears ap_done; cfg_start outside IDLE is ignored.
- CLEAR: writes 0 to data words 0..10 (11 cycles). Then WAIT_IN, or DONE directly if cfg_len==0.
- WAIT_IN: ss_tready=1. On ss_tvalid, data[ptr] <= ss_tdata, acc <= 0, k <= 0, go to MAC.
- MAC (11 cycles, k=0..10): read tap[k] and data[(ptr-k) mod 11]. Each returned pair is accumulated one cycle later: acc += tap*data, low 32 bits of the signed product, wrapping add.
- DRAIN (1 cycle): final product accumulates; ptr <= (ptr==10)?0:ptr+1.
- OUT: sm_tvalid=1, sm_tdata=acc, held until sm_tready. sm_tlast=1 on the cfg_len-th output. After the handshake, go to DONE if count==cfg_len, else WAIT_IN.
- DONE: ap_done=1, ap_idle=1, then go to IDLE in the same cycle. ap_done stays set until cfg_stat_rd or the next accepted cfg_start.
- ss_tlast: error if asserted on any sample but the cfg_len-th, or deasserted on that sample. The error sets err_tlast (cleared by cfg_start) and does not alter sequencing.
- Tap arbitration: cfg_tap_gnt = cfg_tap_req && ap_idle. A request while busy stalls until idle; the engine always wins.
- Addresses are byte addresses (index*4). WE=4'hF for writes, 4'h0 for reads.

## Timing
- BRAM read latency is 1 cycle: Do corresponds to the A/EN of the previous cycle.
- Per sample with sm_tready=1: accept at cycle 0, MAC at cycles 1–11, DRAIN at 12, sm_tvalid at 13. Minimum 14 cycles per sample.
- Reset values: ap_idle=1. ap_done, err_tlast, ss_tready, sm_tvalid, sm_tlast, cfg_tap_gnt, cfg_tap_rvalid = 0. All EN/WE = 0. sm_tdata, cfg_tap_rdata, A and Di buses = 0. ptr, k, count = 0.
- Reset mid-run: immediately back to IDLE values. Data RAM contents are don't-care; the next run's CLEAR restores them.
- cfg_stat_rd and DONE entry in the same cycle: ap_done ends at 1 (set wins).
- cfg_start and cfg_tap_req in the same cycle in IDLE: the tap access is granted and the start is also accepted. Later requests stall.
- ptr wraps 10->0. Read index (ptr-k) mod 11 is computed without a divider: (ptr>=k) ? ptr-k : ptr+11-k.

## Structure
- fir_pkg holds: the state enum; NTAP=11; WORD_BYTES=4; the byte-address function idx*4; and the circular-index function.
- One sub-module, fir_mac: a registered signed 32x32 multiply-accumulate with clear and enable.
- The FSM, counters and arbitration live in fir_sched.

## Test plan
- Reset, no start -> ap_idle=1, ap_done=0, ss_tready=0, all EN low.
- Taps {0,-10,-9,23,56,63,56,23,-9,-10,0}, cfg_len=11, impulse 1,0,...,0 -> sm_tdata sequence equals taps. sm_tlast on the 11th output. Then ap_done=1, ap_idle=1.
- Same taps, constant input 1 for 12 samples -> outputs are running tap sums 0,-10,-19,4,60,123,179,202,193,183,183,183.
- sm_tready held low for 5 cycles at output 3 -> sm_tvalid and sm_tdata stable throughout, ss_tready=0, no sample lost.
- cfg_tap_req read of idx 5 mid-run -> gnt=0 until ap_idle. Then gnt is followed by rvalid with rdata=63.
- cfg_len=3 with ss_tlast on sample 2 -> err_tlast=1. Run still completes 3 outputs. cfg_len=0 start -> ap_done=1 within 2 cycles and no stream traffic.
